// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin two-port burst arbiter and beat sequencer for a shared line memory
module line_mem_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 1024,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_rq0_vld,
   input  logic                  i_rq1_vld,
   input  logic                  i_rq0_we,
   input  logic                  i_rq1_we,
   input  logic [31:0]           i_rq0_addr,
   input  logic [31:0]           i_rq1_addr,
   input  logic [LEN_WIDTH-1:0]  i_rq0_len,
   input  logic [LEN_WIDTH-1:0]  i_rq1_len,
   output logic                  o_rq0_rdy,
   output logic                  o_rq1_rdy,
   output logic                  o_rq0_err,
   output logic                  o_rq1_err,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   input  logic [DATA_WIDTH-1:0] i_rq0_wdata,
   input  logic [DATA_WIDTH-1:0] i_rq1_wdata,
   output logic                  o_rsp0_vld,
   output logic                  o_rsp1_vld,
   output logic                  o_rsp0_last,
   output logic                  o_rsp1_last,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic [31:0]           o_mem_addr,
   output logic                  o_mem_re,
   output logic                  o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;
   logic [0:0]            r_state;
   logic                  r_rr, r_owner, r_we;
   logic [31:0]           r_base;
   logic [LEN_WIDTH-1:0]  r_len, r_cnt;
   logic                  r_rsp0_vld, r_rsp1_vld, r_rsp0_last, r_rsp1_last;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  w_idle, w_burst, w_req, w_pick1, w_err, w_last, w_rd_beat;
   logic [31:0]           w_addr;
   logic [LEN_WIDTH-1:0]  w_len;
   logic                  w_we;
   logic [32:0]           w_end;
   // reset gates every combinational output so nothing leaks while rst_n is low
   assign w_idle    = i_rst_n & (r_state == IDLE);
   assign w_burst   = i_rst_n & (r_state == BURST);
   assign w_req     = i_rq0_vld | i_rq1_vld;
   assign w_pick1   = i_rq1_vld & (~i_rq0_vld | r_rr);
   assign w_addr    = w_pick1 ? i_rq1_addr : i_rq0_addr;
   assign w_len     = w_pick1 ? i_rq1_len : i_rq0_len;
   assign w_we      = w_pick1 ? i_rq1_we : i_rq0_we;
   // 33-bit end address so that huge start addresses cannot wrap into range
   assign w_end     = {1'b0, w_addr} + {{(33-LEN_WIDTH){1'b0}}, w_len};
   assign w_err     = w_end > 33'(DEPTH - 1);
   assign w_last    = r_cnt == r_len;
   assign w_rd_beat = w_burst & ~r_we;
   assign o_rq0_rdy   = w_idle & i_rq0_vld & ~w_pick1;
   assign o_rq1_rdy   = w_idle & w_pick1;
   assign o_rq0_err   = o_rq0_rdy & w_err;
   assign o_rq1_err   = o_rq1_rdy & w_err;
   assign o_gnt0      = w_burst & ~r_owner;
   assign o_gnt1      = w_burst & r_owner;
   assign o_mem_addr  = w_burst ? r_base + {{(32-LEN_WIDTH){1'b0}}, r_cnt} : '0;
   assign o_mem_re    = w_rd_beat;
   assign o_mem_we    = w_burst & r_we;
   assign o_mem_wdata = (w_burst & r_we) ? (r_owner ? i_rq1_wdata : i_rq0_wdata) : '0;
   assign o_rsp0_vld  = r_rsp0_vld;
   assign o_rsp1_vld  = r_rsp1_vld;
   assign o_rsp0_last = r_rsp0_last;
   assign o_rsp1_last = r_rsp1_last;
   assign o_rsp_data  = r_rsp_data;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_rr        <= 1'b0;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_base      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_rsp0_vld  <= 1'b0;
         r_rsp1_vld  <= 1'b0;
         r_rsp0_last <= 1'b0;
         r_rsp1_last <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp0_vld  <= w_rd_beat & ~r_owner;
         r_rsp1_vld  <= w_rd_beat & r_owner;
         r_rsp0_last <= w_rd_beat & ~r_owner & w_last;
         r_rsp1_last <= w_rd_beat & r_owner & w_last;
         if (w_rd_beat) r_rsp_data <= i_mem_rd_data;
         if (r_state == IDLE) begin
            if (w_req) begin
               r_owner <= w_pick1;
               r_base  <= w_addr;
               r_len   <= w_len;
               r_we    <= w_we;
               r_cnt   <= '0;
               if (w_err) r_rr <= ~w_pick1;
               else r_state <= BURST;
            end
         end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_state <= IDLE;
               r_rr    <= ~r_owner;
            end
         end
      end
   end
endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
Two-port burst arbiter and sequencer in front of the single shared line memory (combinational read, write on clk edge, 32-bit word address). It accepts burst read/write requests from two requesters (port 0: fetch/loader, port 1: execute/data), grants the memory to one burst at a time using round-robin, and generates per-beat addresses. It also registers read data back to the owner and rejects out-of-range bursts.

Parameters:
DATA_WIDTH, 64, width of a memory word and of read/write data.
DEPTH, 1024, number of memory words; the valid address range is 0..DEPTH-1.
LEN_WIDTH, 4, width of the burst length field; a burst is len+1 beats, 1..16.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
rq0_vld / rq1_vld  in  1  burst request valid; held until the matching rdy pulse.
rq0_we / rq1_we  in  1  1 = write burst, 0 = read burst.
rq0_addr / rq1_addr  in  32  start word address.
rq0_len / rq1_len  in  LEN_WIDTH  beats minus one.
rq0_rdy / rq1_rdy  out  1  one-cycle accept pulse; request fields are sampled in this cycle.
rq0_err / rq1_err  out  1  one-cycle pulse coincident with rdy when the burst is rejected.
gnt0 / gnt1  out  1  high for each active beat of that port's burst.
rq0_wdata / rq1_wdata  in  DATA_WIDTH  write data for the current beat; must be valid while gnt is high.
rsp0_vld / rsp1_vld  out  1  read beat data valid, one cycle after the beat.
rsp0_last / rsp1_last  out  1  marks the final read beat.
rsp_data  out  DATA_WIDTH  registered read data, shared by both ports and qualified by rspN_vld.
mem_addr  out  32  memory address.
mem_re  out  1  memory read enable.
mem_we  out  1  memory write enable.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_rd_data  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- Reset: all control logic is synchronous on clk with active-low rst_n.
  - On reset: state = IDLE, rr_ptr = 0, beat counter = 0.
  - All outputs are 0, including rsp_data and mem_addr.
- FSM states: IDLE and BURST.
- IDLE, arbitration:
  - If exactly one rqN_vld is high, that port wins.
  - If both are high, port rr_ptr wins; the loser keeps vld high and waits.
  - Winner gets rqN_rdy = 1 in this cycle.
  - addr, len, we and the owner id are latched.
- IDLE, range check: compute end = addr + len in 33-bit arithmetic (no wrap).
  - If end > DEPTH-1: pulse rqN_err with rdy, make no memory access, set rr_ptr = other port, stay in IDLE.
  - Otherwise go to BURST next cycle.
- BURST, per-beat outputs (beat counter cnt runs 0..len):
  - mem_addr = base + cnt; gnt of the owner = 1.
  - Read burst: mem_re = 1.
  - Write burst: mem_we = 1 and mem_wdata = owner's rqN_wdata, passed through combinationally.
- BURST, completion: when cnt == len, go to IDLE next cycle and set rr_ptr = other port.
- Read response: rsp_data <= mem_rd_data and rspN_vld <= 1 for each read beat, so data arrives one cycle after the beat. rsp_last is set on the beat where cnt == len.
- Outside BURST: mem_re, mem_we, gnt0, gnt1 = 0 and mem_addr = 0.
- Timing summary:
  - Accept-to-first-beat latency: 1 cycle.
  - Burst duration: len+1 cycles.
  - Mandatory IDLE gap: 1 cycle between bursts.
  - Requests from the same port are never accepted back-to-back while the other port is waiting.
- The non-owning port's gnt, rsp_vld and rsp_last stay 0 throughout.
- Reset mid-burst: the burst aborts immediately.
  - No mem_we/mem_re in the following cycle.
  - Any in-flight read response is dropped (rsp_vld = 0).
  - Requesters must re-issue.
- vld dropped before rdy: legal, no effect. Fields changing while vld is high without rdy: the request is re-evaluated each IDLE cycle.
- Boundary: a burst ending exactly at DEPTH-1 is accepted. A start address >= DEPTH is always rejected, including addresses >= 2^31.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with rq0_vld = 1 -> all outputs 0; after release, rq0_rdy pulses in the first cycle.
- Port 0 read, addr = 8, len = 3 (memory preloaded with mem[i] = i):
  - mem_re high for 4 cycles with mem_addr 8, 9, 10, 11.
  - rsp0_vld for 4 cycles, one cycle later, with data 8, 9, 10, 11.
  - rsp0_last on data 11; rsp1_vld stays 0.
- Port 1 write then read:
  - Write addr = 100, len = 1, wdata 0xA5 then 0x5A -> mem_we on addresses 100 and 101.
  - Read back -> rsp1 returns 0xA5, 0x5A.
- Contention: both vld out of reset with len = 0, held continuously -> grants alternate 0, 1, 0, 1, each accept separated by beat + IDLE cycles.
- Range error: rq0_addr = DEPTH-2, len = 3 -> rq0_rdy and rq0_err pulse together; no mem_re/mem_we; rr_ptr moves to 1.
- Reset mid-burst: read len = 7, assert rst_n = 0 on beat 3 -> next cycle mem_re = 0, rsp0_vld = 0, state IDLE, rr_ptr = 0.
